d_e_pipe_reg: RTL and testbench

//   D->E pipeline register of the five-stage MIPS core. Captures the decode-stage results
//   (PC, instruction, GRF read data, extended immediate from D_EXT, destination register,

---
 rtl/d_e_pipe_reg.sv | 128 ++++++++++++
 tb/tb_d_e_pipe_reg.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/d_e_pipe_reg.sv
// D->E pipeline register: captures decode results for the execute stage, with
// hold, bubble insertion, Tnew countdown and saturating stall/bubble counters.
module d_e_pipe_reg #(
  parameter int          CTRL_W         = 16,
  parameter logic [31:0] RESET_PC       = 32'h0000_3000,
  parameter bit          BUBBLE_KEEP_PC = 1'b1,
  parameter int          CNT_W          = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic              D_valid,
  input  logic [31:0]       D_PC,
  input  logic [31:0]       D_Instr,
  input  logic [31:0]       D_RD1,
  input  logic [31:0]       D_RD2,
  input  logic [31:0]       D_SignImm,
  input  logic [4:0]        D_WriteReg,
  input  logic [1:0]        D_Tnew,
  input  logic [CTRL_W-1:0] D_ctrl,
  output logic              E_valid,
  output logic [31:0]       E_PC,
  output logic [31:0]       E_Instr,
  output logic [31:0]       E_RD1,
  output logic [31:0]       E_RD2,
  output logic [31:0]       E_SignImm,
  output logic [4:0]        E_WriteReg,
  output logic [1:0]        E_Tnew,
  output logic [CTRL_W-1:0] E_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              valid_q,   valid_d;
  logic [31:0]       pc_q,      pc_d;
  logic [31:0]       instr_q,   instr_d;
  logic [31:0]       rd1_q,     rd1_d;
  logic [31:0]       rd2_q,     rd2_d;
  logic [31:0]       imm_q,     imm_d;
  logic [4:0]        wreg_q,    wreg_d;
  logic [1:0]        tnew_q,    tnew_d;
  logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
  logic [CNT_W-1:0]  stall_q,   stall_d;
  logic [CNT_W-1:0]  bubble_q,  bubble_d;

  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    imm_d    = imm_q;
    wreg_d   = wreg_q;
    tnew_d   = tnew_q;
    ctrl_d   = ctrl_q;
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (clr) begin
      // A bubble must carry WriteReg=0 so forwarding and the GRF see no write.
      valid_d  = 1'b0;
      pc_d     = BUBBLE_KEEP_PC ? D_PC : 32'h0;
      instr_d  = '0;
      rd1_d    = '0;
      rd2_d    = '0;
      imm_d    = '0;
      wreg_d   = '0;
      tnew_d   = '0;
      ctrl_d   = '0;
      bubble_d = (bubble_q == '1) ? bubble_q : bubble_q + CNT_ONE;
    end else if (en) begin
      valid_d = D_valid;
      pc_d    = D_PC;
      instr_d = D_Instr;
      rd1_d   = D_RD1;
      rd2_d   = D_RD2;
      imm_d   = D_SignImm;
      wreg_d  = D_WriteReg;
      tnew_d  = (D_Tnew == 2'd0) ? 2'd0 : D_Tnew - 2'd1;
      ctrl_d  = D_ctrl;
    end else begin
      stall_d = (stall_q == '1) ? stall_q : stall_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
      wreg_q   <= '0;
      tnew_q   <= '0;
      ctrl_q   <= '0;
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      imm_q    <= imm_d;
      wreg_q   <= wreg_d;
      tnew_q   <= tnew_d;
      ctrl_q   <= ctrl_d;
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign E_valid    = valid_q;
  assign E_PC       = pc_q;
  assign E_Instr    = instr_q;
  assign E_RD1      = rd1_q;
  assign E_RD2      = rd2_q;
  assign E_SignImm  = imm_q;
  assign E_WriteReg = wreg_q;
  assign E_Tnew     = tnew_q;
  assign E_ctrl     = ctrl_q;
  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_d_e_pipe_reg.sv
// Directed bench for d_e_pipe_reg: reset, load, Tnew floor, stall, bubble,
// back-to-back loads and asynchronous reset.
module tb_d_e_pipe_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, clr, D_valid;
  logic [31:0] D_PC, D_Instr, D_RD1, D_RD2, D_SignImm;
  logic [4:0]  D_WriteReg;
  logic [1:0]  D_Tnew;
  logic [15:0] D_ctrl;
  logic        E_valid;
  logic [31:0] E_PC, E_Instr, E_RD1, E_RD2, E_SignImm;
  logic [4:0]  E_WriteReg;
  logic [1:0]  E_Tnew;
  logic [15:0] E_ctrl;
  logic [31:0] stall_cnt, bubble_cnt;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  int exp_bubble = 0;

  always #5 clk = ~clk;

  d_e_pipe_reg dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .D_valid(D_valid),
    .D_PC(D_PC), .D_Instr(D_Instr), .D_RD1(D_RD1), .D_RD2(D_RD2),
    .D_SignImm(D_SignImm), .D_WriteReg(D_WriteReg), .D_Tnew(D_Tnew), .D_ctrl(D_ctrl),
    .E_valid(E_valid), .E_PC(E_PC), .E_Instr(E_Instr), .E_RD1(E_RD1), .E_RD2(E_RD2),
    .E_SignImm(E_SignImm), .E_WriteReg(E_WriteReg), .E_Tnew(E_Tnew), .E_ctrl(E_ctrl),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                       input logic [4:0] wr, input logic [1:0] tn, input logic [15:0] ct);
    D_valid = v; D_PC = pc; D_Instr = ins; D_RD1 = r1; D_RD2 = r2;
    D_SignImm = imm; D_WriteReg = wr; D_Tnew = tn; D_ctrl = ct;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en = 1'($urandom); clr = 1'($urandom);
      set_d(1'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom,
            5'($urandom), 2'($urandom), 16'($urandom));
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (E_PC !== 32'h0000_3000) begin
          errors++;
          $display("FAIL reset_pc cyc%0d: got %h want 00003000", i, E_PC);
        end
        checks++;
        if ({E_valid, E_Instr, E_RD1, E_RD2, E_SignImm, E_WriteReg, E_Tnew, E_ctrl,
             stall_cnt, bubble_cnt} !== '0) begin
          errors++;
          $display("FAIL reset_zero cyc%0d: v=%b ins=%h rd1=%h rd2=%h imm=%h wr=%h tn=%h ct=%h st=%0d bb=%0d want all 0",
                   i, E_valid, E_Instr, E_RD1, E_RD2, E_SignImm, E_WriteReg, E_Tnew, E_ctrl,
                   stall_cnt, bubble_cnt);
        end
        #3;
      end
    end
    en = 1'b1; clr = 1'b0;
    set_d(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 16'h0);
    reset = 1'b1;
  endtask

  task automatic test_load();
    en = 1'b1; clr = 1'b0;
    set_d(1'b1, 32'h0000_3004, 32'h2108_0004, 32'h1111_2222, 32'h3333_4444,
          32'hFFFF_8000, 5'd8, 2'd2, 16'hA5C3);
    tick();
    checks++;
    if (E_PC !== 32'h0000_3004) begin errors++; $display("FAIL load_pc: got %h want 00003004", E_PC); end
    checks++;
    if (E_SignImm !== 32'hFFFF_8000) begin errors++; $display("FAIL load_imm: got %h want ffff8000", E_SignImm); end
    checks++;
    if (E_Tnew !== 2'd1) begin errors++; $display("FAIL load_tnew: got %0d want 1", E_Tnew); end
    checks++;
    if (E_WriteReg !== 5'd8) begin errors++; $display("FAIL load_wreg: got %0d want 8", E_WriteReg); end
    checks++;
    if ({E_valid, E_Instr, E_RD1, E_RD2, E_ctrl} !==
        {1'b1, 32'h2108_0004, 32'h1111_2222, 32'h3333_4444, 16'hA5C3}) begin
      errors++;
      $display("FAIL load_other: got v=%b ins=%h rd1=%h rd2=%h ct=%h want 1 21080004 11112222 33334444 a5c3",
               E_valid, E_Instr, E_RD1, E_RD2, E_ctrl);
    end
  endtask

  task automatic test_tnew_floor();
    set_d(1'b1, 32'h0000_3008, 32'h0, 32'h0, 32'h0, 32'h0, 5'd3, 2'd0, 16'h0001);
    tick();
    checks++;
    if (E_Tnew !== 2'd0) begin errors++; $display("FAIL tnew_floor: got %0d want 0", E_Tnew); end
    D_Tnew = 2'd3;
    tick();
    checks++;
    if (E_Tnew !== 2'd2) begin errors++; $display("FAIL tnew_3: got %0d want 2", E_Tnew); end
  endtask

  task automatic test_valid_nogate();
    set_d(1'b0, 32'h0000_4000, 32'hDEAD_BEEF, 32'h5, 32'h6, 32'h7, 5'd17, 2'd1, 16'h00FF);
    tick();
    checks++;
    if ({E_valid, E_PC, E_Instr, E_WriteReg, E_Tnew, E_ctrl} !==
        {1'b0, 32'h0000_4000, 32'hDEAD_BEEF, 5'd17, 2'd0, 16'h00FF}) begin
      errors++;
      $display("FAIL valid_nogate: got v=%b pc=%h ins=%h wr=%0d tn=%0d ct=%h want 0 00004000 deadbeef 17 0 00ff",
               E_valid, E_PC, E_Instr, E_WriteReg, E_Tnew, E_ctrl);
    end
  endtask

  task automatic test_stall();
    set_d(1'b1, 32'h0000_3008, 32'h8C49_0010, 32'hAAAA_0001, 32'hBBBB_0002,
          32'h0000_0010, 5'd9, 2'd2, 16'h1234);
    tick();
    checks++;
    if (E_PC !== 32'h0000_3008) begin errors++; $display("FAIL stall_preload: got %h want 00003008", E_PC); end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_d(1'b0, 32'h5000 + i, $urandom, $urandom, $urandom, $urandom, 5'd31, 2'd3, 16'hFFFF);
      tick();
      exp_stall++;
      checks++;
      if ({E_valid, E_PC, E_Instr, E_RD1, E_RD2, E_SignImm, E_WriteReg, E_Tnew, E_ctrl} !==
          {1'b1, 32'h0000_3008, 32'h8C49_0010, 32'hAAAA_0001, 32'hBBBB_0002,
           32'h0000_0010, 5'd9, 2'd1, 16'h1234}) begin
        errors++;
        $display("FAIL stall_hold%0d: got v=%b pc=%h ins=%h wr=%0d tn=%0d ct=%h want 1 00003008 8c490010 9 1 1234",
                 i, E_valid, E_PC, E_Instr, E_WriteReg, E_Tnew, E_ctrl);
      end
    end
    checks++;
    if (stall_cnt !== 32'd4) begin errors++; $display("FAIL stall_cnt: got %0d want 4", stall_cnt); end
  endtask

  task automatic test_bubble();
    clr = 1'b1; en = 1'b0;
    set_d(1'b1, 32'h0000_300C, 32'h1234_5678, 32'h1, 32'h2, 32'h3, 5'd12, 2'd2, 16'hBEEF);
    tick();
    exp_bubble++;
    checks++;
    if ({E_valid, E_WriteReg, E_ctrl, E_Instr, E_RD1, E_RD2, E_SignImm, E_Tnew} !== '0) begin
      errors++;
      $display("FAIL bubble_zero: got v=%b wr=%0d ct=%h ins=%h rd1=%h rd2=%h imm=%h tn=%0d want all 0",
               E_valid, E_WriteReg, E_ctrl, E_Instr, E_RD1, E_RD2, E_SignImm, E_Tnew);
    end
    checks++;
    if (E_PC !== 32'h0000_300C) begin errors++; $display("FAIL bubble_pc: got %h want 0000300c", E_PC); end
    checks++;
    if (bubble_cnt !== exp_bubble || stall_cnt !== exp_stall) begin
      errors++;
      $display("FAIL bubble_cnts: got bb=%0d st=%0d want bb=%0d st=%0d", bubble_cnt, stall_cnt, exp_bubble, exp_stall);
    end
    en = 1'b1;
    D_PC = 32'h0000_3010;
    tick();
    exp_bubble++;
    checks++;
    if ({E_valid, E_WriteReg, E_PC} !== {1'b0, 5'd0, 32'h0000_3010} || bubble_cnt !== exp_bubble) begin
      errors++;
      $display("FAIL bubble_over_en: got v=%b wr=%0d pc=%h bb=%0d want 0 0 00003010 %0d",
               E_valid, E_WriteReg, E_PC, bubble_cnt, exp_bubble);
    end
    clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    en = 1'b1; clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_d(1'b1, 32'h0000_3100 + 32'(4 * i), 32'h1000_0000 + i, 32'h10 + i, 32'h20 + i,
            32'h30 + i, 5'(i + 1), 2'(i + 1), 16'(16'h0100 + i));
      tick();
      checks++;
      if ({E_PC, E_Instr, E_RD1, E_RD2, E_SignImm, E_WriteReg, E_Tnew, E_ctrl} !==
          {32'h0000_3100 + 32'(4 * i), 32'h1000_0000 + i, 32'h10 + i, 32'h20 + i,
           32'h30 + i, 5'(i + 1), 2'(i), 16'(16'h0100 + i)}) begin
        errors++;
        $display("FAIL b2b%0d: got pc=%h ins=%h rd1=%h wr=%0d tn=%0d ct=%h", i, E_PC, E_Instr, E_RD1,
                 E_WriteReg, E_Tnew, E_ctrl);
      end
    end
    checks++;
    if (stall_cnt !== exp_stall || bubble_cnt !== exp_bubble) begin
      errors++;
      $display("FAIL b2b_cnts: got st=%0d bb=%0d want %0d %0d", stall_cnt, bubble_cnt, exp_stall, exp_bubble);
    end
  endtask

  task automatic test_async_reset();
    en = 1'b0; clr = 1'b0;
    tick();
    exp_stall++;
    checks++;
    if (stall_cnt !== exp_stall) begin errors++; $display("FAIL pre_async_stall: got %0d want %0d", stall_cnt, exp_stall); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (E_PC !== 32'h0000_3000) begin errors++; $display("FAIL async_pc: got %h want 00003000", E_PC); end
    checks++;
    if ({E_valid, E_Instr, E_RD1, E_RD2, E_SignImm, E_WriteReg, E_Tnew, E_ctrl,
         stall_cnt, bubble_cnt} !== '0) begin
      errors++;
      $display("FAIL async_zero: got v=%b ins=%h wr=%0d tn=%0d st=%0d bb=%0d want all 0",
               E_valid, E_Instr, E_WriteReg, E_Tnew, stall_cnt, bubble_cnt);
    end
    tick();
    #3 reset = 1'b1;
    en = 1'b1;
    set_d(1'b1, 32'h0000_3200, 32'h1, 32'h2, 32'h3, 32'h4, 5'd5, 2'd3, 16'h0042);
    tick();
    checks++;
    if ({E_valid, E_PC, E_WriteReg, E_Tnew, stall_cnt, bubble_cnt} !==
        {1'b1, 32'h0000_3200, 5'd5, 2'd2, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL post_async_load: got v=%b pc=%h wr=%0d tn=%0d st=%0d bb=%0d want 1 00003200 5 2 0 0",
               E_valid, E_PC, E_WriteReg, E_Tnew, stall_cnt, bubble_cnt);
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; clr = 1'b0;
    set_d(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 16'h0);
    #2;
    test_reset();
    test_load();
    test_tnew_floor();
    test_valid_nogate();
    test_stall();
    test_bubble();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
